// File: rtl/word_serializer_if.sv
// Handshake and serial-stream bundle between an upstream word source,
// the word serializer and the downstream shift register.
interface word_serializer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic             ready_o;
   logic             ser_o;
   logic             ser_en_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output data_i, valid_i,
      input  ready_o, ser_o, ser_en_o, busy_o, done_o
   );

   modport slave (
      input  data_i, valid_i,
      output ready_o, ser_o, ser_en_o, busy_o, done_o
   );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: accepts one word per handshake and shifts it out MSB
// first, one strobe every DIV cycles, then flags done for one cycle.
module word_serializer #(
   parameter int WIDTH = 16,
   parameter int DIV   = 1
) (
   input logic              clk,
   input logic              reset,
   word_serializer_if.slave bus
);

   if (WIDTH < 1) begin : g_width_check
      $error("word_serializer: WIDTH must be >= 1");
   end
   if (DIV < 1) begin : g_div_check
      $error("word_serializer: DIV must be >= 1");
   end

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] BIT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nxt_s;
   logic [CNT_W-1:0] bit_cnt_r;
   logic [CNT_W-1:0] bit_cnt_nxt_s;
   logic [DIV_W-1:0] div_cnt_r;
   logic [DIV_W-1:0] div_cnt_nxt_s;

   logic ready_r, ser_r, ser_en_r, busy_r, done_r;
   logic ready_nxt_s, ser_nxt_s, ser_en_nxt_s, busy_nxt_s, done_nxt_s;

   // Next-state, datapath and output decode; outputs are derived from the next
   // state so the registered outputs line up with the state they describe.
   always_comb begin
      state_nxt_s   = state_r;
      shift_nxt_s   = shift_r;
      bit_cnt_nxt_s = bit_cnt_r;
      div_cnt_nxt_s = div_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.valid_i) begin
               state_nxt_s   = ST_SHIFT;
               shift_nxt_s   = bus.data_i;
               bit_cnt_nxt_s = BIT_LOAD;
               div_cnt_nxt_s = DIV_ZERO;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (div_cnt_r == DIV_LAST) begin
               div_cnt_nxt_s = DIV_ZERO;
               shift_nxt_s   = shift_r << 1'b1;
               bit_cnt_nxt_s = bit_cnt_r - BIT_ONE;
               if (bit_cnt_r == BIT_ONE) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end else begin
               div_cnt_nxt_s = div_cnt_r + DIV_ONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            shift_nxt_s   = WORD_ZERO;
            bit_cnt_nxt_s = BIT_ZERO;
            div_cnt_nxt_s = DIV_ZERO;
         end
      endcase

      ready_nxt_s  = (state_nxt_s == ST_IDLE);
      busy_nxt_s   = (state_nxt_s != ST_IDLE);
      done_nxt_s   = (state_nxt_s == ST_DONE);
      ser_en_nxt_s = (state_nxt_s == ST_SHIFT) && (div_cnt_nxt_s == DIV_LAST);
      ser_nxt_s    = ser_en_nxt_s & shift_nxt_s[WIDTH-1];
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         shift_r   <= WORD_ZERO;
         bit_cnt_r <= BIT_ZERO;
         div_cnt_r <= DIV_ZERO;
         ready_r   <= 1'b1;
         ser_r     <= 1'b0;
         ser_en_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shift_r   <= shift_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         div_cnt_r <= div_cnt_nxt_s;
         ready_r   <= ready_nxt_s;
         ser_r     <= ser_nxt_s;
         ser_en_r  <= ser_en_nxt_s;
         busy_r    <= busy_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   assign bus.ready_o  = ready_r;
   assign bus.ser_o    = ser_r;
   assign bus.ser_en_o = ser_en_r;
   assign bus.busy_o   = busy_r;
   assign bus.done_o   = done_r;

endmodule
